// File: rtl/touch_pkg.sv
// Shared encodings for touch-pad key controllers: LED modes and gesture states.
package touch_pkg;

  // LED mode as seen on the mode output; value 3 is never produced.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  // Gesture classifier states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRESS = 3'd1,
    WAIT2 = 3'd2,
    LHOLD = 3'd3,
    DHOLD = 3'd4
  } gest_e;

  // Mode reached after a classified gesture event (only one of s/d/l is ever set).
  function automatic mode_e mode_after_event(input mode_e cur, input logic s,
                                             input logic d, input logic l);
    mode_e nxt;
    nxt = cur;
    if (l) begin
      nxt = MODE_OFF;
    end else if (d) begin
      nxt = MODE_BLINK;
    end else if (s) begin
      case (cur)
        MODE_OFF:   nxt = MODE_ON;
        MODE_ON:    nxt = MODE_OFF;
        MODE_BLINK: nxt = MODE_OFF;
        default:    nxt = MODE_OFF;
      endcase
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/touch_debounce.sv
// Two-flop synchroniser plus stability-counter debounce for the raw touch pad.
// rise_o/fall_o are asserted in the cycle *before* touch_db_o changes, so a
// consumer registering on them acts on the same edge the debounced level moves.
module touch_debounce
  import touch_pkg::*;
#(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic touch_i,
  output logic touch_db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 32'd1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounce next state: count while synced input disagrees, adopt it after DEB_CYC cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q >= CNT_MAX) begin
      db_d  = sync2_q;
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
  end

  // Synchroniser, debounced level and stability counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= touch_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign touch_db_o = db_q;
  assign rise_o     = ~db_q & db_d;
  assign fall_o     = db_q & ~db_d;

endmodule

// File: rtl/touch_led_ctrl.sv
// Touch pad to LED controller: debounce, gesture classification
// (short / double / long press) and LED mode FSM with blink generator.
module touch_led_ctrl
  import touch_pkg::*;
#(
  parameter int unsigned DEB_CYC    = 1_000_000,
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned DBL_CYC    = 15_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch,
  output logic       led,
  output logic [1:0] mode,
  output logic       ev_short,
  output logic       ev_double,
  output logic       ev_long
);

  localparam int unsigned HW = $clog2(LONG_CYC + 1);
  localparam int unsigned GW = $clog2(DBL_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC - 32'd1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(DBL_CYC - 32'd1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 32'd1);

  logic db_s, rise_s, fall_s;

  gest_e         gest_q, gest_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ev_short_q, ev_short_d;
  logic          ev_double_q, ev_double_d;
  logic          ev_long_q, ev_long_d;
  mode_e         mode_q, mode_d;
  logic          led_q, led_d;
  logic [BW-1:0] blink_q, blink_d;

  touch_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_deb (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .touch_i    (touch),
    .touch_db_o (db_s),
    .rise_o     (rise_s),
    .fall_o     (fall_s)
  );

  // Gesture classifier: next state, hold/gap counters and one-cycle event pulses.
  always_comb begin
    gest_d      = gest_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    ev_short_d  = 1'b0;
    ev_double_d = 1'b0;
    ev_long_d   = 1'b0;
    case (gest_q)
      IDLE: begin
        if (rise_s) begin
          gest_d = PRESS;
          hold_d = {HW{1'b0}};
        end else begin
          gest_d = IDLE;
        end
      end
      PRESS: begin
        if (hold_q >= HOLD_MAX) begin
          ev_long_d = 1'b1;
          gest_d    = LHOLD;
        end else if (fall_s) begin
          gest_d = WAIT2;
          gap_d  = {GW{1'b0}};
        end else begin
          hold_d = hold_q + HW'(1'b1);
        end
      end
      WAIT2: begin
        if (rise_s && (gap_q < GAP_MAX)) begin
          ev_double_d = 1'b1;
          gest_d      = DHOLD;
        end else if (gap_q >= GAP_MAX) begin
          // Gap expired: the first press was a short one. A press landing on
          // this very cycle is kept as the start of a new gesture.
          ev_short_d = 1'b1;
          hold_d     = {HW{1'b0}};
          gest_d     = rise_s ? PRESS : IDLE;
        end else begin
          gap_d = gap_q + GW'(1'b1);
        end
      end
      LHOLD: begin
        if (!db_s) begin
          gest_d = IDLE;
        end else begin
          gest_d = LHOLD;
        end
      end
      DHOLD: begin
        if (!db_s) begin
          gest_d = IDLE;
        end else begin
          gest_d = DHOLD;
        end
      end
      default: begin
        gest_d = IDLE;
      end
    endcase
  end

  // LED mode and drive: mode follows the registered event, blink restarts lit on entry.
  always_comb begin
    mode_d  = mode_after_event(mode_q, ev_short_q, ev_double_q, ev_long_q);
    led_d   = led_q;
    blink_d = blink_q;
    case (mode_d)
      MODE_OFF: begin
        led_d   = 1'b0;
        blink_d = {BW{1'b0}};
      end
      MODE_ON: begin
        led_d   = 1'b1;
        blink_d = {BW{1'b0}};
      end
      MODE_BLINK: begin
        if (mode_q != MODE_BLINK) begin
          led_d   = 1'b1;
          blink_d = {BW{1'b0}};
        end else if (blink_q >= BLINK_MAX) begin
          led_d   = ~led_q;
          blink_d = {BW{1'b0}};
        end else begin
          blink_d = blink_q + BW'(1'b1);
        end
      end
      default: begin
        led_d   = 1'b0;
        blink_d = {BW{1'b0}};
      end
    endcase
  end

  // State registers for gesture FSM, events, mode, LED and blink counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      gest_q      <= IDLE;
      hold_q      <= {HW{1'b0}};
      gap_q       <= {GW{1'b0}};
      ev_short_q  <= 1'b0;
      ev_double_q <= 1'b0;
      ev_long_q   <= 1'b0;
      mode_q      <= MODE_OFF;
      led_q       <= 1'b0;
      blink_q     <= {BW{1'b0}};
    end else begin
      gest_q      <= gest_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      ev_short_q  <= ev_short_d;
      ev_double_q <= ev_double_d;
      ev_long_q   <= ev_long_d;
      mode_q      <= mode_d;
      led_q       <= led_d;
      blink_q     <= blink_d;
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign ev_short  = ev_short_q;
  assign ev_double = ev_double_q;
  assign ev_long   = ev_long_q;

endmodule

// File: tb/tb_touch_led_ctrl.sv
// Scoreboard bench for touch_led_ctrl: gestures are issued with randomized
// durations, the expected event (kind, cycle, resulting mode/LED) is queued
// when issued, and a negedge monitor pops and compares whenever an event fires.
module tb_touch_led_ctrl;

  localparam int DEB     = 4;
  localparam int LONG    = 40;
  localparam int DBL     = 20;
  localparam int BLINK   = 8;
  localparam int DEB_LAT = DEB + 2;   // 2 sync flops + DEB stable cycles

  localparam int K_SHORT  = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       touch     = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       ev_short, ev_double, ev_long;

  touch_led_ctrl #(
    .DEB_CYC    (DEB),
    .LONG_CYC   (LONG),
    .DBL_CYC    (DBL),
    .BLINK_HALF (BLINK)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .touch     (touch),
    .led       (led),
    .mode      (mode),
    .ev_short  (ev_short),
    .ev_double (ev_double),
    .ev_long   (ev_long)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         at;
    logic [1:0] mode;
    bit         chk_led;
    logic       led;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] sb_mode = 2'd0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // LED mode table: short toggles OFF<->ON and leaves BLINK to OFF, double -> BLINK, long -> OFF.
  function automatic logic [1:0] next_mode(input logic [1:0] m, input int kind);
    if (kind == K_LONG) return 2'd0;
    if (kind == K_DOUBLE) return 2'd2;
    return (m == 2'd0) ? 2'd1 : 2'd0;
  endfunction

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind    = kind;
    e.at      = at;
    e.mode    = next_mode(sb_mode, kind);
    e.chk_led = !(kind == K_DOUBLE && sb_mode == 2'd2);
    e.led     = (e.mode != 2'd0);
    sb_mode   = e.mode;
    sbq.push_back(e);
  endtask

  task automatic set_touch(input logic v, output int c);
    @(posedge sys_clk);
    #1;
    touch = v;
    c = cyc;
  endtask

  task automatic hold(input logic v, input int len);
    int c;
    set_touch(v, c);
    repeat (len - 1) @(posedge sys_clk);
  endtask

  task automatic short_press(input int len);
    int f;
    hold(1'b1, len);
    set_touch(1'b0, f);
    push(K_SHORT, f + DEB_LAT + DBL);
    repeat (DEB_LAT + DBL + 12) @(posedge sys_clk);
  endtask

  task automatic double_press(input int l1, input int gap, input int l2);
    int r, x;
    hold(1'b1, l1);
    hold(1'b0, gap);
    set_touch(1'b1, r);
    push(K_DOUBLE, r + DEB_LAT);
    repeat (l2 - 1) @(posedge sys_clk);
    set_touch(1'b0, x);
    repeat (DEB_LAT + 12) @(posedge sys_clk);
  endtask

  task automatic long_press(input int len);
    int c, x;
    set_touch(1'b1, c);
    push(K_LONG, c + DEB_LAT + LONG);
    repeat (len - 1) @(posedge sys_clk);
    set_touch(1'b0, x);
    repeat (DEB_LAT + 12) @(posedge sys_clk);
  endtask

  // Monitor: pops the scoreboard on every event pulse, checks mode/LED and blink timing.
  exp_t       cur;
  logic [1:0] mdl_mode = 2'd0;
  bit         pend     = 1'b0;
  int         last_tog = 0;
  logic       prev_led = 1'b0;
  logic [1:0] prev_mode = 2'd0;

  initial begin
    int nev, act;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        mdl_mode = 2'd0;
        pend     = 1'b0;
      end else begin
        if (pend) begin
          check("mode_after_event", int'(mode), int'(cur.mode));
          if (cur.chk_led) check("led_after_event", int'(led), int'(cur.led));
          mdl_mode = cur.mode;
          pend     = 1'b0;
        end else begin
          check("mode_steady", int'(mode), int'(mdl_mode));
        end
        if (mode == 2'd0) check("led_in_off", int'(led), 0);
        if (mode == 2'd1) check("led_in_on", int'(led), 1);
        if (mode == 2'd2 && prev_mode != 2'd2) last_tog = cyc;
        if (mode == 2'd2 && prev_mode == 2'd2) begin
          if (led != prev_led) begin
            check("blink_half_period", cyc - last_tog, BLINK);
            last_tog = cyc;
          end else if (cyc - last_tog > BLINK) begin
            check("blink_stuck", cyc - last_tog, BLINK);
            last_tog = cyc;
          end
        end
        nev = int'(ev_short) + int'(ev_double) + int'(ev_long);
        if (nev > 1) check("events_per_cycle", nev, 1);
        if (nev >= 1) begin
          if (sbq.size() == 0) begin
            check("unexpected_event", nev, 0);
          end else begin
            cur = sbq.pop_front();
            act = ev_short ? K_SHORT : (ev_double ? K_DOUBLE : K_LONG);
            check("event_kind", act, cur.kind);
            check("event_cycle", cyc, cur.at);
            pend = 1'b1;
          end
        end
      end
      prev_led  = led;
      prev_mode = mode;
    end
  end

  // Time limit: the stimulus is finite, so this only fires on a broken run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // Stimulus: directed scenarios followed by a randomized gesture mix.
  initial begin
    int k, l1, g, l2, saw_db;
    // Reset with the pad chattering.
    repeat (10) begin
      @(posedge sys_clk);
      #1 touch = 1'($urandom_range(0, 1));
    end
    @(posedge sys_clk);
    #1 touch = 1'b0;
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("reset_mode", int'(mode), 0);
    check("reset_led", int'(led), 0);
    check("reset_events", int'(ev_short) + int'(ev_double) + int'(ev_long), 0);

    // Glitch shorter than the debounce window.
    hold(1'b1, 2);
    touch  = 1'b0;
    saw_db = 0;
    repeat (12) begin
      @(negedge sys_clk);
      saw_db = saw_db | int'(dut.u_deb.touch_db_o);
    end
    check("glitch_db", saw_db, 0);
    check("glitch_mode", int'(mode), 0);

    // Short presses: OFF->ON, ON->OFF.
    short_press(15);
    check("short1_mode", int'(mode), 1);
    short_press(15);
    check("short2_mode", int'(mode), 0);

    // Double press into BLINK, watch several blink periods.
    double_press(10, 8, 10);
    repeat (5 * 2 * BLINK) @(posedge sys_clk);
    @(negedge sys_clk);
    check("double_mode", int'(mode), 2);

    // Long hold from BLINK back to OFF.
    long_press(100);
    check("long_mode", int'(mode), 0);

    // Reset while waiting for a second press: no short event afterwards.
    short_press(12);
    hold(1'b1, 10);
    hold(1'b0, 10);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    sb_mode = 2'd0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (DBL + DEB_LAT + 20) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_mid_gesture_mode", int'(mode), 0);
    short_press(15);
    check("after_reset_short_mode", int'(mode), 1);

    // Randomized gesture mix.
    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: short_press(int'($urandom_range(6, 30)));
        1: begin
          l1 = int'($urandom_range(6, 20));
          g  = int'($urandom_range(6, 15));
          l2 = int'($urandom_range(6, 60));
          double_press(l1, g, l2);
        end
        2: long_press(int'($urandom_range(50, 120)));
        default: begin
          hold(1'b1, int'($urandom_range(1, 3)));
          touch = 1'b0;
          repeat (20) @(posedge sys_clk);
        end
      endcase
    end

    repeat (50) @(posedge sys_clk);
    check("missing_events", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
